// File: rtl/gcd_pkg.sv
// Shared types and constants for the gcd_engine family.
// The state encoding is also driven onto the State debug port, so it must stay fixed.
package gcd_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    LOAD_X = 2'd0,
    LOAD_Y = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } gcd_state_e;

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, compare flags and the single subtractor of the GCD engine.
// Only the larger operand is ever reduced, so the subtraction cannot underflow.
module gcd_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_x,
  input  logic             load_y,
  input  logic             sub_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             any_zero,
  output logic             x_eq_y,
  output logic             x_gt_y
);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;

  assign any_zero = (x_q == '0) || (y_q == '0);
  assign x_eq_y   = (x_q == y_q);
  assign x_gt_y   = (x_q > y_q);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_x) begin
      x_d = din;
    end else if (sub_en && x_gt_y) begin
      x_d = x_q - y_q;
    end
    if (load_y) begin
      y_d = din;
    end else if (sub_en && !x_gt_y) begin
      y_d = y_q - x_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/gcd_engine.sv
// Subtractive GCD engine with an Enter/Input operand handshake and a Halt result flag.
// Defining GCD_ITER_COUNT_EN adds the Iter port, which counts the subtractions of the last run.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Enter,
  input  logic [WIDTH-1:0]   Input,
  output logic [WIDTH-1:0]   Output,
  output logic               Halt,
`ifdef GCD_ITER_COUNT_EN
  output logic [STATE_W-1:0] State,
  output logic [WIDTH-1:0]   Iter
`else
  output logic [STATE_W-1:0] State
`endif
);

  gcd_state_e       state_q, state_d;
  logic             enter_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic             halt_q, halt_d;

  logic             enter_rise;
  logic             load_x, load_y, sub_en;
  logic [WIDTH-1:0] x, y;
  logic             any_zero, x_eq_y, x_gt_y;

  assign enter_rise = Enter & ~enter_q;

  gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (Clock),
    .rst      (Reset),
    .load_x   (load_x),
    .load_y   (load_y),
    .sub_en   (sub_en),
    .din      (Input),
    .x        (x),
    .y        (y),
    .any_zero (any_zero),
    .x_eq_y   (x_eq_y),
    .x_gt_y   (x_gt_y)
  );

  // Edges arriving during RUN fall through unused, so they cannot be replayed later.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    halt_d  = halt_q;
    load_x  = 1'b0;
    load_y  = 1'b0;
    sub_en  = 1'b0;
    case (state_q)
      LOAD_X: begin
        if (enter_rise) begin
          load_x  = 1'b1;
          state_d = LOAD_Y;
        end
      end
      LOAD_Y: begin
        if (enter_rise) begin
          load_y  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (any_zero) begin
          out_d   = x | y;
          halt_d  = 1'b1;
          state_d = DONE;
        end else if (x_eq_y) begin
          out_d   = x;
          halt_d  = 1'b1;
          state_d = DONE;
        end else begin
          sub_en = 1'b1;
        end
      end
      DONE: begin
        if (enter_rise) begin
          load_x  = 1'b1;
          halt_d  = 1'b0;
          state_d = LOAD_Y;
        end
      end
      default: state_d = LOAD_X;
    endcase
  end

  // enter_q resets high so an Enter held through reset release is not a rising edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= LOAD_X;
      enter_q <= 1'b1;
      out_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= Enter;
      out_q   <= out_d;
      halt_q  <= halt_d;
    end
  end

  assign Output = out_q;
  assign Halt   = halt_q;
  assign State  = state_q;

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_q, iter_d;

  always_comb begin
    iter_d = iter_q;
    if (load_y) begin
      iter_d = '0;
    end else if (sub_en && (iter_q != {WIDTH{1'b1}})) begin
      iter_d = iter_q + WIDTH'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

  assign Iter = iter_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: an 8-bit and a 16-bit instance driven from one linear sequence.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_gcd_engine;

  logic        clock = 1'b0;
  logic        rst8, rst16;
  logic        en8, en16;
  logic [7:0]  in8, out8;
  logic [15:0] in16, out16;
  logic        halt8, halt16;
  logic [1:0]  state8, state16;
`ifdef GCD_ITER_COUNT_EN
  logic [7:0]  iter8;
  logic [15:0] iter16;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int cycles;

  always #5 clock = ~clock;

  gcd_engine #(.WIDTH(8)) dut8 (
    .Clock  (clock),
    .Reset  (rst8),
    .Enter  (en8),
    .Input  (in8),
    .Output (out8),
    .Halt   (halt8),
`ifdef GCD_ITER_COUNT_EN
    .State  (state8),
    .Iter   (iter8)
`else
    .State  (state8)
`endif
  );

  gcd_engine #(.WIDTH(16)) dut16 (
    .Clock  (clock),
    .Reset  (rst16),
    .Enter  (en16),
    .Input  (in16),
    .Output (out16),
    .Halt   (halt16),
`ifdef GCD_ITER_COUNT_EN
    .State  (state16),
    .Iter   (iter16)
`else
    .State  (state16)
`endif
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One Enter pulse followed by one low cycle, so back-to-back calls give distinct edges.
  task automatic apply_stimulus(input bit wide, input logic [15:0] value);
    if (wide) begin en16 = 1'b1; in16 = value; end
    else      begin en8  = 1'b1; in8  = value[7:0]; end
    @(negedge clock);
    if (wide) en16 = 1'b0; else en8 = 1'b0;
    @(negedge clock);
  endtask

  // Returns j such that Halt rose at capture edge k + j; start is the edge count already elapsed.
  task automatic wait_halt(input bit wide, input int start, output int cyc);
    cyc = start;
    while (!(wide ? halt16 : halt8) && cyc < 70000) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  initial begin
    logic [15:0] ra, rb;

    rst8 = 1'b1; rst16 = 1'b1;
    en8 = 1'b1; in8 = 8'd55;
    en16 = 1'b0; in16 = '0;
    repeat (2) @(negedge clock);
    check_output("rst_state8", state8, 0);
    check_output("rst_out8", out8, 0);
    check_output("rst_halt8", halt8, 0);
    check_output("rst_state16", state16, 0);
`ifdef GCD_ITER_COUNT_EN
    check_output("rst_iter8", iter8, 0);
`endif

    // Enter stays high across reset release
    rst8 = 1'b0; rst16 = 1'b0;
    repeat (3) @(negedge clock);
    check_output("held_thru_reset_state", state8, 0);
    en8 = 1'b0;
    @(negedge clock);

    apply_stimulus(0, 12);
    check_output("x_loaded_state", state8, 1);
    apply_stimulus(0, 18);
    wait_halt(0, 1, cycles);
    check_output("gcd12_18_latency", cycles, 3);
    check_output("gcd12_18_out", out8, 6);
    check_output("gcd12_18_state", state8, 3);
`ifdef GCD_ITER_COUNT_EN
    check_output("gcd12_18_iter", iter8, 2);
`endif

    apply_stimulus(0, 127);
    check_output("x_from_done_halt", halt8, 0);
    check_output("x_from_done_state", state8, 1);
    check_output("keep_out_on_load", out8, 6);
    apply_stimulus(0, 1);
    wait_halt(0, 1, cycles);
    check_output("worst_latency", cycles, 127);
    check_output("worst_out", out8, 1);
`ifdef GCD_ITER_COUNT_EN
    check_output("worst_iter", iter8, 126);
`endif

    apply_stimulus(0, 0);
    apply_stimulus(0, 9);
    wait_halt(0, 1, cycles);
    check_output("zero_x_latency", cycles, 1);
    check_output("zero_x_out", out8, 9);
`ifdef GCD_ITER_COUNT_EN
    check_output("zero_x_iter", iter8, 0);
`endif
    apply_stimulus(0, 0);
    apply_stimulus(0, 0);
    wait_halt(0, 1, cycles);
    check_output("zero_zero_out", out8, 0);
    check_output("zero_zero_halt", halt8, 1);

    // Enter high for 5 cycles with Input changing: only the first value may be captured
    en8 = 1'b1; in8 = 8'd40;
    @(negedge clock);
    in8 = 8'd99;
    repeat (4) @(negedge clock);
    check_output("enter_held_state", state8, 1);
    en8 = 1'b0;
    @(negedge clock);
    apply_stimulus(0, 24);
    wait_halt(0, 1, cycles);
    check_output("enter_held_latency", cycles, 4);
    check_output("enter_held_out", out8, 8);

    // Enter pulse during RUN: gcd(50,7) still needs 13 subtractions
    apply_stimulus(0, 50);
    apply_stimulus(0, 7);
    apply_stimulus(0, 5);
    wait_halt(0, 3, cycles);
    check_output("run_pulse_latency", cycles, 14);
    check_output("run_pulse_out", out8, 1);
`ifdef GCD_ITER_COUNT_EN
    check_output("run_pulse_iter", iter8, 13);
`endif
    repeat (2) @(negedge clock);
    check_output("run_pulse_stays_done", state8, 3);

    apply_stimulus(0, 100);
    apply_stimulus(0, 3);
    repeat (9) @(negedge clock);
    check_output("midrun_state", state8, 2);
    rst8 = 1'b1;
    #1;
    check_output("midrun_rst_state", state8, 0);
    check_output("midrun_rst_halt", halt8, 0);
    check_output("midrun_rst_out", out8, 0);
    @(negedge clock);
    rst8 = 1'b0;
    @(negedge clock);
    apply_stimulus(0, 8);
    apply_stimulus(0, 12);
    wait_halt(0, 1, cycles);
    check_output("after_rst_latency", cycles, 3);
    check_output("after_rst_out", out8, 4);

    apply_stimulus(1, 16'd65535);
    apply_stimulus(1, 16'd255);
    wait_halt(1, 1, cycles);
    check_output("wide_latency", cycles, 257);
    check_output("wide_out", out16, 255);
`ifdef GCD_ITER_COUNT_EN
    check_output("wide_iter", iter16, 256);
`endif
    apply_stimulus(1, 16'd1000);
    check_output("wide_b2b_halt_fall", halt16, 0);
    check_output("wide_b2b_state", state16, 1);
    apply_stimulus(1, 16'd600);
    wait_halt(1, 1, cycles);
    check_output("wide_b2b_latency", cycles, 4);
    check_output("wide_b2b_out", out16, 200);

    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom_range(1, 1023));
      rb = 16'($urandom_range(1, 1023));
      apply_stimulus(1, ra);
      apply_stimulus(1, rb);
      wait_halt(1, 1, cycles);
      check_output($sformatf("rand_%0d_%0d", ra, rb), {15'd0, halt16, out16}, {15'd0, 1'b1, ref_gcd(ra, rb)});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gcd_engine.md
# gcd_engine

Parametrised successor to the 8-bit EC2 GCD microprocessor. It accepts two unsigned operands over the existing `Enter`/`Input` handshake, computes their greatest common divisor by repeated subtraction (one subtraction per clock), then presents the result with `Halt`. It is a drop-in replacement wherever the EC2 core sits between the front-panel input logic and the output display, and it adds operand width, zero-operand handling and defined re-entry.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be at least 2.
- `Clock` input, 1 bit: single clock; all state updates on the rising edge.
- `Reset` input, 1 bit: asynchronous, active-high reset.
- `Enter` input, 1 bit: operand strobe, sampled on the rising edge.
- `Input` input, `WIDTH` bits: operand value; valid on the cycle `Enter` is first seen high.
- `Output` output, `WIDTH` bits: GCD result, registered.
- `Halt` output, 1 bit: high while the result is valid.
- `State` output, 2 bits: current FSM state, for debug and display.
- `Iter` output, `WIDTH` bits: only when `GCD_ITER_COUNT_EN` is defined; number of subtractions in the last computation.

## Operation
- Reset values:
  - `State` = LOAD_X, `Output` = 0, `Halt` = 0, X = Y = 0.
  - `Iter` = 0.
  - Enter-edge register = 1, so an `Enter` held high through reset release does not capture an operand.
- Edge detection:
  - `enter_rise` = `Enter` & ~`enter_q`, where `enter_q` is the `Enter` value from the previous cycle.
  - Every capture uses `enter_rise`. Holding `Enter` high for several cycles captures exactly once.
- FSM encoding is LOAD_X = 0, LOAD_Y = 1, RUN = 2, DONE = 3.
  - LOAD_X: on `enter_rise`, X <= `Input` and go to LOAD_Y.
  - LOAD_Y: on `enter_rise`, Y <= `Input` and go to RUN.
  - RUN: evaluate one rule per cycle, in this priority order:
    1. X==0 or Y==0: `Output` <= X|Y, go to DONE.
    2. X==Y: `Output` <= X, go to DONE.
    3. X>Y: X <= X−Y.
    4. Otherwise: Y <= Y−X.
  - RUN ignores `Enter`; an edge seen during RUN is discarded.
  - DONE: `Halt`=1 and `Output` is held. On `enter_rise`, X <= `Input`, `Halt` <= 0 and go to LOAD_Y.
- Arithmetic:
  - Unsigned `WIDTH`-bit arithmetic throughout.
  - Subtraction is only performed on the larger operand, so it never underflows.
  - gcd(0,0) = 0. gcd(a,0) = gcd(0,a) = a.
- `Output` keeps the last result until the next DONE entry; it is not cleared when new operands are loaded.
- Reset asserted in any state, including mid-RUN, immediately forces the reset values. The partial computation is lost.

## Timing
- Y is captured at clock edge k, which also enters RUN.
- For a computation needing N subtractions, `Halt` and `Output` update at edge k+N+1.
  - Example: gcd(12,18) takes N=2 (subtractions give Y=6, then X=6).
  - Worst case is N = 2^WIDTH − 2, for the pair (2^WIDTH−1, 1).
- Minimum operand spacing: X and Y need two distinct `enter_rise` events, so `Enter` must be low for at least one sampled cycle between them.
- `Halt` deasserts on the edge that captures the next X. There is no other way to clear it except reset.

## Configuration
- `GCD_ITER_COUNT_EN`:
  - Defined: adds the `Iter` port. The counter clears on entering RUN and increments on each subtraction; it saturates at all-ones. Its value is held in DONE and LOAD states. Reset value is 0.
  - Undefined: no port and no counter logic. All other behaviour is identical.

## Structure
- `gcd_pkg` holds:
  - The state enum: LOAD_X, LOAD_Y, RUN, DONE, with 2-bit encoding exactly as listed in Operation.
  - `STATE_W` = 2.
- Sub-module `gcd_datapath`, parameterised by `WIDTH`:
  - Contains the X/Y registers, the load muxes, the comparator (zero, equal, greater-than flags) and the subtractor.
  - The top level `gcd_engine` keeps the FSM, Enter-edge logic, `Output`/`Halt` registers and the optional counter.

## Test plan
- Basic result, `WIDTH`=8: load X=12, then Y=18 → `Halt`=1 at Y-edge+3, `Output`=6, `State`=3, `Iter`=2.
- Worst-case run, `WIDTH`=8: load X=127, Y=1 → `Halt` at Y-edge+127, `Output`=1, `Iter`=126.
- Zero operands: X=0, Y=9 gives `Output`=9 one cycle after Y capture; X=0, Y=0 gives `Output`=0 with `Halt`=1.
- Handshake robustness:
  - `Enter` held high for 5 cycles captures only X.
  - `Enter` pulsed during RUN has no effect.
  - `Enter` held high through reset release captures nothing.
- Reset mid-run: load 100 and 3, assert `Reset` 10 cycles into RUN → `State`=0, `Halt`=0, `Output`=0. A new pair 8, 12 then gives `Output`=4.
- Wide and back-to-back, `WIDTH`=16:
  - Load 65535 and 255 → `Output`=255.
  - From DONE, load 1000 and 600 → `Halt` falls on the X capture, then `Output`=200.
  - 100 random nonzero pairs are checked against a reference-model GCD.
